mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline register between the MEM stage (data memory) and write-back (register file).
- Captures the data memory read word and the EX/MEM control and ALU result.
- For loads, selects the byte or halfword lane, then sign- or zero-extends it. Chooses the write-back value: memory data or ALU result.
- Detects misaligned accesses and keeps load/store retire counters and a sticky halt flag for the debug unit.

Parameters:
- B, 32, data/address width in bits
- RA, 5, register-file address width
- CNT_W, 16, retire counter width

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  1 = advance; 0 = stall (hold all registers)
- i_flush  in  1  insert bubble
- i_clear_err  in  1  clears sticky misalignment flag and captured address
- i_valid  in  1  incoming instruction is valid
- i_mem_data  in  B  full aligned word from data memory (o_data of data_mem)
- i_alu_result  in  B  byte address / ALU result
- i_rd_addr  in  RA  destination register
- i_reg_write  in  1  instruction writes rd
- i_mem_to_reg  in  1  1 = write back load data, 0 = ALU result
- i_mem_read  in  1  load
- i_mem_write  in  1  store
- i_bhw  in  2  access size: 00 byte, 01 halfword, 11 word, 10 treated as word
- i_unsigned  in  1  zero-extend (LBU/LHU) when 1
- i_halt  in  1  halt instruction marker
- o_valid  out  1  registered valid
- o_wb_data  out  B  write-back value
- o_rd_addr  out  RA  registered rd
- o_reg_write  out  1  register-file write enable
- o_misaligned  out  1  sticky misalignment flag
- o_err_addr  out  B  address of first misaligned access
- o_load_count  out  CNT_W  retired loads
- o_store_count  out  CNT_W  retired stores
- o_halt  out  1  sticky halt-retired flag

Behaviour:
- Reset (i_reset_n=0, async): all outputs 0.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N.
- Priority per edge: reset > flush > stall > advance.
- Flush: o_valid=0, o_reg_write=0, o_wb_data=0, o_rd_addr=0. Flush applies even when i_enable=0. Counters, halt and error flags are unchanged.
- Stall: every register, counters included, holds its value.
- Advance, lane select with off=i_alu_result[1:0]:
  - byte: i_mem_data[8*off+7 : 8*off]
  - halfword: i_mem_data[16*off[1]+15 : 16*off[1]]
  - word: full word
- Extension: sign-extend from the lane MSB unless i_unsigned=1. i_unsigned is ignored for word accesses.
- o_wb_data = extended load data if i_mem_to_reg=1, otherwise i_alu_result.
- Misaligned = i_valid & (i_mem_read|i_mem_write) & ((halfword & off[0]) | (word & off!=0)).
- On misaligned:
  - o_reg_write=0 for that instruction.
  - Store still counts as not retired.
  - o_misaligned is set.
  - o_err_addr is captured only if o_misaligned was 0, so only the first error address is kept.
- i_clear_err (advance or stall) clears o_misaligned and o_err_addr. A simultaneous new misalignment wins: flag set, new address captured.
- o_reg_write = i_valid & i_reg_write & (i_rd_addr!=0) & ~misaligned.
- o_load_count increments on each valid, aligned i_mem_read. o_store_count increments on each valid, aligned i_mem_write. Both wrap modulo 2^CNT_W.
- o_halt: set when a valid i_halt advances. Cleared only by reset.
- Invalid instruction (i_valid=0) with enable: o_valid=0, o_reg_write=0, no counter/flag change.

Test Plan:
- Reset mid-run: counters at 5, drive i_reset_n=0 between edges -> all outputs 0 immediately, without waiting for a clock edge.
- Byte loads: i_mem_data=0x80FF7F01, bhw=00, addr 0..3, signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Unsigned at addr 3 -> 0x00000080. o_load_count=5.
- Halfword/word: i_mem_data=0x8001F00F. Halfword addr 0 signed -> 0xFFFFF00F. Halfword addr 2 unsigned -> 0x00008001. Word addr 4 -> 0x8001F00F. ALU op with mem_to_reg=0, alu=0x1234, rd=7 -> o_wb_data=0x1234, o_reg_write=1.
- Misalignment: halfword load addr 0x5, rd=3 -> o_reg_write=0, o_misaligned=1, o_err_addr=0x5. Word load addr 0x6 -> o_err_addr stays 0x5. i_clear_err -> flag 0, o_err_addr 0.
- Stall/flush: valid store with i_enable=0 for 3 cycles -> outputs and o_store_count hold. Flush with enable=0 -> o_valid=0, counters unchanged. Then enable -> store retires, o_store_count+1.
- rd=0 and halt: reg_write to rd=0 -> o_reg_write=0. Valid i_halt -> o_halt=1 and remains 1 after later flushes.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load lane select and extension, write-back mux,
// misalignment capture, and load/store/halt retire status for the debug unit.
module mem_wb_stage #(
    parameter int B     = 32,
    parameter int RA    = 5,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_flush,
    input  logic             i_clear_err,
    input  logic             i_valid,
    input  logic [B-1:0]     i_mem_data,
    input  logic [B-1:0]     i_alu_result,
    input  logic [RA-1:0]    i_rd_addr,
    input  logic             i_reg_write,
    input  logic             i_mem_to_reg,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic [1:0]       i_bhw,
    input  logic             i_unsigned,
    input  logic             i_halt,
    output logic             o_valid,
    output logic [B-1:0]     o_wb_data,
    output logic [RA-1:0]    o_rd_addr,
    output logic             o_reg_write,
    output logic             o_misaligned,
    output logic [B-1:0]     o_err_addr,
    output logic [CNT_W-1:0] o_load_count,
    output logic [CNT_W-1:0] o_store_count,
    output logic             o_halt
);

    logic [1:0]   off;
    logic         is_byte;
    logic         is_half;
    logic         is_word;
    logic [7:0]   byte_lane;
    logic [15:0]  half_lane;
    logic [B-1:0] load_data;
    logic [B-1:0] wb_next;
    logic         misaligned;
    logic         reg_write_next;
    logic         load_retire;
    logic         store_retire;

    assign off     = i_alu_result[1:0];
    assign is_byte = (i_bhw == 2'b00);
    assign is_half = (i_bhw == 2'b01);
    assign is_word = i_bhw[1];   // 10 is treated as a word access

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        byte_lane = i_mem_data[{off, 3'b000} +: 8];
        half_lane = i_mem_data[{off[1], 4'b0000} +: 16];
        load_data = i_mem_data;
        if (is_byte) begin
            load_data = {{(B-8){byte_lane[7] & ~i_unsigned}}, byte_lane};
        end else if (is_half) begin
            load_data = {{(B-16){half_lane[15] & ~i_unsigned}}, half_lane};
        end
    end

    assign wb_next        = i_mem_to_reg ? load_data : i_alu_result;
    assign misaligned     = i_valid & (i_mem_read | i_mem_write)
                          & ((is_half & off[0]) | (is_word & (off != 2'b00)));
    assign reg_write_next = i_valid & i_reg_write & (i_rd_addr != '0) & ~misaligned;
    assign load_retire    = i_valid & i_mem_read  & ~misaligned;
    assign store_retire   = i_valid & i_mem_write & ~misaligned;

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid     <= 1'b0;
            o_wb_data   <= '0;
            o_rd_addr   <= '0;
            o_reg_write <= 1'b0;
        end else if (i_flush) begin
            o_valid     <= 1'b0;
            o_wb_data   <= '0;
            o_rd_addr   <= '0;
            o_reg_write <= 1'b0;
        end else if (i_enable) begin
            o_valid     <= i_valid;
            o_wb_data   <= wb_next;
            o_rd_addr   <= i_rd_addr;
            o_reg_write <= reg_write_next;
        end
    end

    // Status survives flushes; only the error clear acts while stalled.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_misaligned  <= 1'b0;
            o_err_addr    <= '0;
            o_load_count  <= '0;
            o_store_count <= '0;
            o_halt        <= 1'b0;
        end else if (!i_flush) begin
            if (i_enable && misaligned) begin
                o_misaligned <= 1'b1;
                if (!o_misaligned || i_clear_err) begin
                    o_err_addr <= i_alu_result;
                end
            end else if (i_clear_err) begin
                o_misaligned <= 1'b0;
                o_err_addr   <= '0;
            end
            if (i_enable) begin
                if (load_retire)  o_load_count  <= o_load_count + 1'b1;
                if (store_retire) o_store_count <= o_store_count + 1'b1;
                if (i_valid && i_halt) o_halt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus random traffic,
// scored against a behavioural model through an expected-value queue.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable, flush, clear_err, valid;
    logic [31:0] mem_data, alu;
    logic [4:0]  rd;
    logic        reg_write, mem_to_reg, mem_read, mem_write, uns, halt;
    logic [1:0]  bhw;

    logic        o_valid, o_reg_write, o_misaligned, o_halt;
    logic [31:0] o_wb_data, o_err_addr;
    logic [4:0]  o_rd_addr;
    logic [15:0] o_load_count, o_store_count;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_flush(flush),
        .i_clear_err(clear_err), .i_valid(valid), .i_mem_data(mem_data),
        .i_alu_result(alu), .i_rd_addr(rd), .i_reg_write(reg_write),
        .i_mem_to_reg(mem_to_reg), .i_mem_read(mem_read), .i_mem_write(mem_write),
        .i_bhw(bhw), .i_unsigned(uns), .i_halt(halt),
        .o_valid(o_valid), .o_wb_data(o_wb_data), .o_rd_addr(o_rd_addr),
        .o_reg_write(o_reg_write), .o_misaligned(o_misaligned), .o_err_addr(o_err_addr),
        .o_load_count(o_load_count), .o_store_count(o_store_count), .o_halt(o_halt)
    );

    typedef struct {
        logic        valid;
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic [31:0] err;
        logic [15:0] lc;
        logic [15:0] sc;
        logic        halt;
        logic        known;   // wb/rd are defined (valid result, flush or reset)
    } exp_t;

    exp_t m;
    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [31:0] word, input logic [1:0] a,
                                               input logic [1:0] size, input logic u);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (word >> (8 * a)) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (word >> (16 * (a / 2))) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    task automatic model_reset();
        m = '{valid: 0, wb: 0, rd: 0, rw: 0, mis: 0, err: 0, lc: 0, sc: 0, halt: 0, known: 1};
    endtask

    task automatic model_step();
        int  a;
        bit  bad;
        a   = int'(alu % 4);
        bad = valid && (mem_read || mem_write) &&
              ((bhw == 2'b01 && (a % 2) == 1) || (bhw >= 2'b10 && a != 0));
        if (flush) begin
            m.valid = 0; m.rw = 0; m.wb = 0; m.rd = 0; m.known = 1;
        end else if (!enable) begin
            if (clear_err) begin m.mis = 0; m.err = 0; end
        end else begin
            if (clear_err) begin m.mis = 0; m.err = 0; end
            if (bad) begin
                if (!m.mis) m.err = alu;
                m.mis = 1;
            end
            m.valid = valid;
            m.rw    = valid && reg_write && rd != 0 && !bad;
            m.wb    = mem_to_reg ? load_value(mem_data, a[1:0], bhw, uns) : alu;
            m.rd    = rd;
            m.known = valid;
            if (valid && mem_read  && !bad) m.lc = m.lc + 1;
            if (valid && mem_write && !bad) m.sc = m.sc + 1;
            if (valid && halt) m.halt = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        q.push_back(m);
        #1;
    endtask

    task automatic idle();
        enable = 1; flush = 0; clear_err = 0; valid = 0; mem_data = 0; alu = 0; rd = 0;
        reg_write = 0; mem_to_reg = 0; mem_read = 0; mem_write = 0; bhw = 2'b11; uns = 0; halt = 0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        input logic u, input logic [4:0] r);
        idle();
        valid = 1; alu = a; mem_data = d; bhw = s; uns = u; rd = r;
        reg_write = 1; mem_to_reg = 1; mem_read = 1;
        cycle();
    endtask

    // Monitor: compares DUT outputs against the queued model state mid-cycle.
    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("sb_valid", o_valid, e.valid);
            check("sb_reg_write", o_reg_write, e.rw);
            check("sb_misaligned", o_misaligned, e.mis);
            check("sb_err_addr", o_err_addr, e.err);
            check("sb_load_count", o_load_count, e.lc);
            check("sb_store_count", o_store_count, e.sc);
            check("sb_halt", o_halt, e.halt);
            if (e.known) begin
                check("sb_wb_data", o_wb_data, e.wb);
                check("sb_rd_addr", o_rd_addr, e.rd);
            end
        end
    end

    initial begin
        logic [31:0] held_wb;
        idle();
        model_reset();
        #3;
        check("reset_valid", o_valid, 0);
        check("reset_wb", o_wb_data, 0);
        check("reset_counts", {o_load_count, o_store_count}, 0);
        @(negedge clk);
        rst_n = 1;

        // Byte loads, signed then unsigned
        load(32'h100, 32'h80FF7F01, 2'b00, 0, 5'd1); check("lb_0", o_wb_data, 32'h0000_0001);
        load(32'h101, 32'h80FF7F01, 2'b00, 0, 5'd1); check("lb_1", o_wb_data, 32'h0000_007F);
        load(32'h102, 32'h80FF7F01, 2'b00, 0, 5'd1); check("lb_2", o_wb_data, 32'hFFFF_FFFF);
        load(32'h103, 32'h80FF7F01, 2'b00, 0, 5'd1); check("lb_3", o_wb_data, 32'hFFFF_FF80);
        load(32'h103, 32'h80FF7F01, 2'b00, 1, 5'd1); check("lbu_3", o_wb_data, 32'h0000_0080);
        check("lb_count", o_load_count, 5);

        // Asynchronous reset between edges
        idle();
        @(negedge clk); #1;
        rst_n = 0;
        #1;
        check("async_rst_valid", o_valid, 0);
        check("async_rst_wb", o_wb_data, 0);
        check("async_rst_lc", o_load_count, 0);
        check("async_rst_rw", o_reg_write, 0);
        model_reset();
        #1 rst_n = 1;

        // Halfword / word / ALU result
        load(32'h0, 32'h8001F00F, 2'b01, 0, 5'd2); check("lh_0", o_wb_data, 32'hFFFF_F00F);
        load(32'h2, 32'h8001F00F, 2'b01, 1, 5'd2); check("lhu_2", o_wb_data, 32'h0000_8001);
        load(32'h4, 32'h8001F00F, 2'b11, 0, 5'd2); check("lw_4", o_wb_data, 32'h8001_F00F);
        idle(); valid = 1; alu = 32'h1234; rd = 5'd7; reg_write = 1; cycle();
        check("alu_wb", o_wb_data, 32'h1234);
        check("alu_rw", o_reg_write, 1);

        // Misalignment capture and clear
        load(32'h5, 32'h0, 2'b01, 0, 5'd3);
        check("mis_rw", o_reg_write, 0);
        check("mis_flag", o_misaligned, 1);
        check("mis_addr", o_err_addr, 32'h5);
        load(32'h6, 32'h0, 2'b11, 0, 5'd3);
        check("mis_addr_kept", o_err_addr, 32'h5);
        idle(); clear_err = 1; cycle();
        check("clr_flag", o_misaligned, 0);
        check("clr_addr", o_err_addr, 0);

        // Stall, flush while stalled, then retire the store
        idle(); cycle();
        held_wb = o_wb_data;
        idle(); valid = 1; mem_write = 1; alu = 32'h40; enable = 0;
        repeat (3) cycle();
        check("stall_sc", o_store_count, 0);
        check("stall_valid", o_valid, 0);
        check("stall_wb", o_wb_data, held_wb);
        flush = 1; cycle(); flush = 0;
        check("flush_valid", o_valid, 0);
        check("flush_sc", o_store_count, 0);
        enable = 1; cycle();
        check("store_sc", o_store_count, 1);

        // rd = 0 and sticky halt
        idle(); valid = 1; reg_write = 1; rd = 0; alu = 32'h99; cycle();
        check("rd0_rw", o_reg_write, 0);
        idle(); valid = 1; halt = 1; cycle();
        check("halt_set", o_halt, 1);
        idle(); flush = 1; repeat (2) cycle();
        check("halt_sticky", o_halt, 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            idle();
            enable     = ($urandom_range(0, 9) < 8);
            flush      = ($urandom_range(0, 99) < 8);
            clear_err  = ($urandom_range(0, 99) < 5);
            valid      = ($urandom_range(0, 3) != 0);
            mem_data   = $urandom;
            alu        = $urandom;
            rd         = 5'($urandom_range(0, 31));
            reg_write  = $urandom_range(0, 1) == 1;
            mem_to_reg = $urandom_range(0, 1) == 1;
            mem_read   = $urandom_range(0, 2) == 0;
            mem_write  = !mem_read && ($urandom_range(0, 2) == 0);
            bhw        = 2'($urandom_range(0, 3));
            uns        = $urandom_range(0, 1) == 1;
            halt       = ($urandom_range(0, 99) < 2);
            cycle();
        end

        idle();
        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
